// File: rtl/hazard_decoder_if.sv
// Fetch-side and issue-side handshake bundle for the hazard-aware decode stage.
interface hazard_decoder_if #(
    parameter int FWD_DEPTH = 2
);
    localparam int FW = $clog2(2*FWD_DEPTH+1);

    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instruction;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    op, rd, rs, func, rt;
    logic [15:0]   imm;
    logic [19:0]   offs;
    logic [FW-1:0] rs_fwd, rt_fwd;
    logic          rd_fwd;
    logic [31:0]   issued_count;
    logic [31:0]   bubble_count;

    modport master (
        output in_valid, instruction, flush, out_ready,
        input  in_ready, out_valid, op, rd, rs, func, rt, imm, offs,
               rs_fwd, rt_fwd, rd_fwd, issued_count, bubble_count
    );

    modport slave (
        input  in_valid, instruction, flush, out_ready,
        output in_ready, out_valid, op, rd, rs, func, rt, imm, offs,
               rs_fwd, rt_fwd, rd_fwd, issued_count, bubble_count
    );
endinterface

// File: rtl/hazard_decoder.sv
// Decode stage: splits instruction fields, searches a FWD_DEPTH writeback history
// for operand forwarding and inserts load-use / jump-register interlock bubbles.
module hazard_decoder #(
    parameter int  FWD_DEPTH       = 2,
    parameter int  LOAD_USE_STALL  = 1,
    parameter int  JR_STALL_CYCLES = 1,
    localparam int FW              = $clog2(2*FWD_DEPTH+1)
) (
    input  logic            clk,
    input  logic            rst_async,
    hazard_decoder_if.slave bus
);
    // Opcode encoding shared with the rest of the pipeline.
    localparam logic [3:0] OP_NOOP  = 4'h0, OP_ARITH = 4'h1, OP_AR_IM = 4'h2,
                           OP_TEST  = 4'h3, OP_TS_IM = 4'h4, OP_LOAD  = 4'h5,
                           OP_JR    = 4'h8, OP_JALR  = 4'hA;

    typedef struct packed {
        logic       vld;
        logic       ld;
        logic [3:0] rd;
    } hist_t;
    typedef hist_t [FWD_DEPTH-1:0] hist_vec_t;

    typedef struct packed {
        logic [3:0]    op, rd, rs, func, rt;
        logic [15:0]   imm;
        logic [19:0]   offs;
        logic [FW-1:0] rs_fwd, rt_fwd;
        logic          rd_fwd;
    } dec_t;

    typedef enum logic {RUN, STALL} state_t;

    state_t      state;
    logic [2:0]  stall_cnt;
    hist_vec_t   hist;
    dec_t        dec_q, dec_d;
    logic        out_valid_q;
    logic [31:0] issued_q, bubble_q;

    logic [3:0]  in_op, in_rd, in_rs, in_rt;
    logic        is_load, is_wb, is_jr, advance, need_stall, issue, bubble;
    logic [2:0]  stall_len;
    hist_t       new_entry;

    function automatic logic hit(hist_t e, logic [3:0] r);
        return e.vld && (e.rd != 4'd0) && (e.rd == r);
    endfunction

    // Walk oldest to newest so the nearest matching producer wins.
    function automatic logic [FW-1:0] fwd_sel(hist_vec_t h, logic [3:0] r);
        logic [FW-1:0] sel;
        sel = '0;
        for (int k = FWD_DEPTH-1; k >= 0; k--)
            if (hit(h[k], r)) sel = h[k].ld ? FW'(FWD_DEPTH+k+1) : FW'(k+1);
        return sel;
    endfunction

    assign in_op = bus.instruction[31:28];
    assign in_rd = bus.instruction[27:24];
    assign in_rs = bus.instruction[23:20];
    assign in_rt = bus.instruction[3:0];

    always_comb begin
        is_load    = (in_op == OP_LOAD);
        is_wb      = (in_op inside {OP_ARITH, OP_AR_IM, OP_TEST, OP_TS_IM}) || is_load;
        is_jr      = (in_op inside {OP_JR, OP_JALR});
        advance    = !out_valid_q || bus.out_ready;
        need_stall = bus.in_valid &&
                     ((is_jr && hit(hist[0], in_rs)) ||
                      ((LOAD_USE_STALL != 0) && hist[0].ld &&
                       (hit(hist[0], in_rs) || hit(hist[0], in_rt))));
        bus.in_ready = !rst_async &&
                       (bus.flush || (advance && state == RUN && !need_stall));
        issue      = bus.in_valid && bus.in_ready && !bus.flush;
        bubble     = (state == STALL) || need_stall;
        stall_len  = is_jr ? 3'(JR_STALL_CYCLES) : 3'd1;
        new_entry  = issue ? {is_wb, is_load, in_rd} : '0;
        dec_d      = {in_op, in_rd, in_rs, bus.instruction[19:16], in_rt,
                      bus.instruction[15:0], bus.instruction[19:0],
                      fwd_sel(hist, in_rs), fwd_sel(hist, in_rt), hit(hist[0], in_rd)};
    end

    // The detecting edge is itself the first bubble, so stall_cnt holds the remainder.
    always_ff @(posedge clk or posedge rst_async) begin
        if (rst_async) begin
            state       <= RUN;
            stall_cnt   <= '0;
            hist        <= '0;
            dec_q       <= '0;
            out_valid_q <= 1'b0;
            issued_q    <= '0;
            bubble_q    <= '0;
        end else if (bus.flush) begin
            state       <= RUN;
            stall_cnt   <= '0;
            hist        <= '0;
            out_valid_q <= 1'b0;
        end else if (advance) begin
            for (int k = FWD_DEPTH-1; k > 0; k--) hist[k] <= hist[k-1];
            hist[0]     <= new_entry;
            out_valid_q <= issue;
            if (issue) begin
                dec_q <= dec_d;
                if (in_op != OP_NOOP && !(&issued_q)) issued_q <= issued_q + 32'd1;
            end
            if (bubble && !(&bubble_q)) bubble_q <= bubble_q + 32'd1;
            if (state == STALL) begin
                stall_cnt <= stall_cnt - 3'd1;
                if (stall_cnt == 3'd1) state <= RUN;
            end else if (need_stall) begin
                stall_cnt <= stall_len - 3'd1;
                if (stall_len > 3'd1) state <= STALL;
            end
        end
    end

    assign bus.out_valid    = out_valid_q;
    assign bus.op           = dec_q.op;
    assign bus.rd           = dec_q.rd;
    assign bus.rs           = dec_q.rs;
    assign bus.func         = dec_q.func;
    assign bus.rt           = dec_q.rt;
    assign bus.imm          = dec_q.imm;
    assign bus.offs         = dec_q.offs;
    assign bus.rs_fwd       = dec_q.rs_fwd;
    assign bus.rt_fwd       = dec_q.rt_fwd;
    assign bus.rd_fwd       = dec_q.rd_fwd;
    assign bus.issued_count = issued_q;
    assign bus.bubble_count = bubble_q;
endmodule
